// File: rtl/contrast_gain_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : contrast_gain_ctrl_if
// Description : Pixel-stream, control and gain signals between the frame
//               source and the contrast gain controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface contrast_gain_ctrl_if;
   logic       frame_start;
   logic       frame_end;
   logic       pixel_valid;
   logic [7:0] point_data_in;
   logic       auto_en;
   logic [2:0] manual_value;
   logic       process_en;
   logic [2:0] mul_value;
   logic       image_process_start;
   logic       gain_update;
   logic [7:0] frame_peak;

   modport master (
      output frame_start, frame_end, pixel_valid, point_data_in,
             auto_en, manual_value, process_en,
      input  mul_value, image_process_start, gain_update, frame_peak
   );

   modport slave (
      input  frame_start, frame_end, pixel_valid, point_data_in,
             auto_en, manual_value, process_en,
      output mul_value, image_process_start, gain_update, frame_peak
   );
endinterface
`default_nettype wire

// File: rtl/contrast_gain_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : contrast_gain_ctrl
// Description : Per-frame peak tracker that picks the largest non-clipping
//               gain code for the downstream point contrast stage.
// Revision    : 1.0 - initial release
// ============================================================================
module contrast_gain_ctrl #(
   parameter int GAIN_MAX   = 7,
   parameter int GAIN_MIN   = 4,
   parameter int CLIP_LIMIT = 1023
) (
   input logic                 clk,
   input logic                 rst,
   contrast_gain_ctrl_if.slave bus
);

   localparam logic [2:0]  c_gain_max   = 3'(GAIN_MAX);
   localparam logic [2:0]  c_gain_min   = 3'(GAIN_MIN);
   localparam logic [10:0] c_clip_limit = 11'(CLIP_LIMIT);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_CALC   = 2'd1,
      S_UPDATE = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_next;

   logic        r_in_frame;
   logic [7:0]  r_acc;
   logic        r_pixel_seen;
   logic [7:0]  r_calc_peak;
   logic [2:0]  r_cand;
   logic [2:0]  r_mul_value;
   logic        r_gain_update;
   logic        r_image_process_start;
   logic [7:0]  r_frame_peak;

   logic [7:0]  w_peak_now;
   logic        w_frame_close;
   logic        w_start_calc;
   logic [10:0] w_product;
   logic        w_fits;
   logic        w_calc_done;

   // Peak including a pixel that arrives on the frame_end cycle itself.
   assign w_peak_now    = (bus.pixel_valid && (bus.point_data_in > r_acc)) ?
                          bus.point_data_in : r_acc;
   assign w_frame_close = bus.frame_end && r_in_frame;
   assign w_start_calc  = w_frame_close && (r_pixel_seen || bus.pixel_valid) &&
                          (r_state == S_IDLE);
   assign w_product     = {3'b000, r_calc_peak} * {8'h00, r_cand};
   assign w_fits        = (w_product <= c_clip_limit);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_calc_done  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_start_calc) begin
               w_state_next = S_CALC;
            end
         end
         S_CALC: begin
            if (w_fits || (r_cand == c_gain_min)) begin
               w_calc_done  = 1'b1;
               w_state_next = S_UPDATE;
            end
         end
         S_UPDATE: begin
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_in_frame            <= 1'b0;
         r_acc                 <= 8'd0;
         r_pixel_seen          <= 1'b0;
         r_calc_peak           <= 8'd0;
         r_cand                <= c_gain_max;
         r_mul_value           <= c_gain_min;
         r_gain_update         <= 1'b0;
         r_image_process_start <= 1'b0;
         r_frame_peak          <= 8'd0;
      end else begin
         if (w_frame_close) begin
            r_frame_peak <= w_peak_now;
            r_in_frame   <= 1'b0;
         end
         if (w_start_calc) begin
            r_calc_peak <= w_peak_now;
         end

         // A coincident frame_start opens the next frame after the old one closes.
         if (bus.frame_start) begin
            r_in_frame   <= 1'b1;
            r_acc        <= bus.pixel_valid ? bus.point_data_in : 8'd0;
            r_pixel_seen <= bus.pixel_valid;
         end else if (r_in_frame && bus.pixel_valid) begin
            r_acc        <= w_peak_now;
            r_pixel_seen <= 1'b1;
         end

         if (w_start_calc) begin
            r_cand <= c_gain_max;
         end else if ((r_state == S_CALC) && !w_calc_done) begin
            r_cand <= r_cand - 3'd1;
         end

         if (!bus.auto_en) begin
            r_mul_value <= bus.manual_value;
         end else if (w_calc_done) begin
            r_mul_value <= r_cand;
         end
         r_gain_update         <= w_calc_done && bus.auto_en;
         r_image_process_start <= bus.process_en;
      end
   end

   assign bus.mul_value           = r_mul_value;
   assign bus.gain_update         = r_gain_update;
   assign bus.image_process_start = r_image_process_start;
   assign bus.frame_peak          = r_frame_peak;

endmodule
`default_nettype wire

// File: tb/tb_contrast_gain_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_contrast_gain_ctrl
// Description : Self-checking bench for contrast_gain_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_contrast_gain_ctrl;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   contrast_gain_ctrl_if bus ();

   contrast_gain_ctrl #(
      .GAIN_MAX   (7),
      .GAIN_MIN   (4),
      .CLIP_LIMIT (1023)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic [3:0][7:0] px;
      logic [2:0]      n;
      logic            last_v;
      logic [7:0]      last_px;
      logic [7:0]      exp_peak;
      logic [2:0]      exp_code;
   } vec_t;

   typedef struct {
      int code;
      int cycle;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[12];

   function automatic vec_t mk(input int a, input int b, input int c, input int n,
                               input int lv, input int lp, input int peak, input int code);
      vec_t v;
      v.px[0]    = 8'(a);
      v.px[1]    = 8'(b);
      v.px[2]    = 8'(c);
      v.px[3]    = 8'd0;
      v.n        = 3'(n);
      v.last_v   = 1'(lv);
      v.last_px  = 8'(lp);
      v.exp_peak = 8'(peak);
      v.exp_code = 3'(code);
      return v;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step(input logic fs, input logic fe, input logic pv, input logic [7:0] px);
      bus.frame_start   = fs;
      bus.frame_end     = fe;
      bus.pixel_valid   = pv;
      bus.point_data_in = px;
      @(posedge clk);
      #1;
      bus.frame_start   = 1'b0;
      bus.frame_end     = 1'b0;
      bus.pixel_valid   = 1'b0;
      bus.point_data_in = 8'd0;
   endtask

   // Call in the cycle that will carry frame_end.
   task automatic expect_gain(input int code);
      exp_t e;
      e.code  = code;
      e.cycle = cyc + 2 + (7 - code);
      sb.push_back(e);
   endtask

   task automatic run_vec(input vec_t v);
      step(1'b1, 1'b0, 1'b0, 8'd0);
      for (int i = 0; i < int'(v.n); i++) step(1'b0, 1'b0, 1'b1, v.px[i]);
      expect_gain(int'(v.exp_code));
      step(1'b0, 1'b1, v.last_v, v.last_px);
      check("frame_peak", int'(bus.frame_peak), int'(v.exp_peak));
      repeat (8) step(1'b0, 1'b0, 1'b0, 8'd0);
      check("mul_value_settled", int'(bus.mul_value), int'(v.exp_code));
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (bus.gain_update === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_gain_update: pulse at cycle %0d, expected none", cyc);
         end else begin
            e = sb.pop_front();
            check("gain_code", int'(bus.mul_value), e.code);
            check("gain_cycle", cyc, e.cycle);
         end
      end
   end

   initial begin
      rst               = 1'b1;
      bus.frame_start   = 1'b0;
      bus.frame_end     = 1'b0;
      bus.pixel_valid   = 1'b0;
      bus.point_data_in = 8'd0;
      bus.auto_en       = 1'b1;
      bus.manual_value  = 3'd0;
      bus.process_en    = 1'b0;

      vecs[0]  = mk(10, 255, 30, 3, 0, 0, 255, 4);
      vecs[1]  = mk(100, 0, 50, 3, 0, 0, 100, 7);
      vecs[2]  = mk(160, 20, 5, 3, 0, 0, 160, 6);
      vecs[3]  = mk(180, 1, 2, 3, 0, 0, 180, 5);
      vecs[4]  = mk(50, 100, 90, 3, 1, 200, 200, 5);
      vecs[5]  = mk(146, 0, 0, 1, 0, 0, 146, 7);
      vecs[6]  = mk(147, 0, 0, 1, 0, 0, 147, 6);
      vecs[7]  = mk(170, 0, 0, 1, 0, 0, 170, 6);
      vecs[8]  = mk(171, 0, 0, 1, 0, 0, 171, 5);
      vecs[9]  = mk(204, 0, 0, 1, 0, 0, 204, 5);
      vecs[10] = mk(205, 0, 0, 1, 0, 0, 205, 4);
      vecs[11] = mk(0, 0, 0, 2, 0, 0, 0, 7);

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset_mul_value", int'(bus.mul_value), 4);
      check("reset_gain_update", int'(bus.gain_update), 0);
      check("reset_frame_peak", int'(bus.frame_peak), 0);
      check("reset_process_start", int'(bus.image_process_start), 0);

      for (int i = 0; i < 12; i++) run_vec(vecs[i]);

      // Coincident start/end: old frame peak 150, new frame begins with pixel 90.
      step(1'b1, 1'b0, 1'b0, 8'd0);
      step(1'b0, 1'b0, 1'b1, 8'd150);
      expect_gain(6);
      step(1'b1, 1'b1, 1'b1, 8'd90);
      check("coincident_old_peak", int'(bus.frame_peak), 150);
      repeat (6) step(1'b0, 1'b0, 1'b0, 8'd0);
      step(1'b0, 1'b0, 1'b1, 8'd40);
      expect_gain(7);
      step(1'b0, 1'b1, 1'b0, 8'd0);
      check("coincident_new_peak", int'(bus.frame_peak), 90);
      repeat (8) step(1'b0, 1'b0, 1'b0, 8'd0);

      // Pixel-less frame and stray frame_end leave the gain alone.
      run_vec(vecs[10]);
      step(1'b1, 1'b0, 1'b0, 8'd0);
      step(1'b0, 1'b0, 1'b0, 8'd0);
      step(1'b0, 1'b1, 1'b0, 8'd0);
      check("empty_frame_peak", int'(bus.frame_peak), 0);
      repeat (8) step(1'b0, 1'b0, 1'b0, 8'd0);
      check("empty_frame_mul", int'(bus.mul_value), 4);
      step(1'b0, 1'b1, 1'b1, 8'd77);
      check("stray_end_peak", int'(bus.frame_peak), 0);
      repeat (8) step(1'b0, 1'b0, 1'b0, 8'd0);
      check("stray_end_mul", int'(bus.mul_value), 4);

      // Manual mode.
      bus.auto_en      = 1'b0;
      bus.manual_value = 3'd3;
      step(1'b0, 1'b0, 1'b0, 8'd0);
      check("manual_mul", int'(bus.mul_value), 3);
      step(1'b1, 1'b0, 1'b0, 8'd0);
      step(1'b0, 1'b0, 1'b1, 8'd100);
      step(1'b0, 1'b1, 1'b0, 8'd0);
      check("manual_frame_peak", int'(bus.frame_peak), 100);
      repeat (8) step(1'b0, 1'b0, 1'b0, 8'd0);
      check("manual_mul_held", int'(bus.mul_value), 3);
      bus.manual_value = 3'd5;
      step(1'b0, 1'b0, 1'b0, 8'd0);
      check("manual_mul_5", int'(bus.mul_value), 5);
      bus.auto_en = 1'b1;
      repeat (4) step(1'b0, 1'b0, 1'b0, 8'd0);
      check("auto_switch_hold", int'(bus.mul_value), 5);

      bus.process_en = 1'b1;
      step(1'b0, 1'b0, 1'b0, 8'd0);
      check("process_start_hi", int'(bus.image_process_start), 1);
      bus.process_en = 1'b0;
      step(1'b0, 1'b0, 1'b0, 8'd0);
      check("process_start_lo", int'(bus.image_process_start), 0);

      // Reset lands on the second CALC cycle of a peak-255 frame.
      step(1'b1, 1'b0, 1'b0, 8'd0);
      step(1'b0, 1'b0, 1'b1, 8'd255);
      step(1'b0, 1'b1, 1'b0, 8'd0);
      step(1'b0, 1'b0, 1'b0, 8'd0);
      rst = 1'b1;
      step(1'b0, 1'b0, 1'b0, 8'd0);
      rst = 1'b0;
      check("midcalc_reset_mul", int'(bus.mul_value), 4);
      check("midcalc_reset_peak", int'(bus.frame_peak), 0);
      repeat (8) step(1'b0, 1'b0, 1'b0, 8'd0);
      check("midcalc_reset_mul_after", int'(bus.mul_value), 4);

      repeat (4) step(1'b0, 1'b0, 1'b0, 8'd0);
      while (sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL missing_gain_update: got none, expected code %0d at cycle %0d",
                  sb[0].code, sb[0].cycle);
         void'(sb.pop_front());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
